// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared constants and level-count helpers for the pipelined mux tree
package mux_pkg;

  localparam int MAX_N = 256;

  // Number of 4:1 levels needed to reduce n inputs to one (last level may be 2:1).
  function automatic int clog4(input int n);
    int l;
    int v;
    l = 0;
    v = 1;
    while (v < n) begin
      v = v * 4;
      l = l + 1;
    end
    return l;
  endfunction

  // Number of words entering level k of a tree with n leaves.
  function automatic int lvl_count(input int n, input int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) begin
      c = (c + 3) / 4;
    end
    return c;
  endfunction

endpackage

// File: rtl/mux4_stage.sv
// rtl/mux4_stage.sv - one registered 4:1 slice carrying data, valid bit and channel tag
module mux4_stage #(
  parameter int W     = 8,
  parameter int SEL_W = 4,
  parameter int LEVEL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [4*W-1:0]     d_in,
  input  logic [3:0]         v_in,
  input  logic [4*SEL_W-1:0] t_in,
  output logic [W-1:0]       d_out,
  output logic               v_out,
  output logic [SEL_W-1:0]   t_out
);

  logic [1:0] pick;

  // All four children carry the same tag, so slot 0 drives the select; an odd
  // select width leaves only one bit for the final level, making it a 2:1.
  if (2 * LEVEL + 1 < SEL_W) begin : g_pick4
    assign pick = t_in[2*LEVEL +: 2];
  end else begin : g_pick2
    assign pick = {1'b0, t_in[2*LEVEL]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_out <= '0;
      v_out <= 1'b0;
      t_out <= '0;
    end else if (en) begin
      d_out <= d_in[pick*W +: W];
      v_out <= v_in[pick];
      t_out <= t_in[pick*SEL_W +: SEL_W];
    end
  end

endmodule

// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N:1 mux tree with direct or scan-counter selection
module mux_tree_pipe
  import mux_pkg::*;
#(
  parameter int W     = 8,
  parameter int N     = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [SEL_W-1:0] sel,
  input  logic             scan_mode,
  input  logic             scan_load,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [W-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int L = clog4(N);

  if (SEL_W != $clog2(N)) begin : g_bad_sel
    $error("mux_tree_pipe: SEL_W must equal log2(N)");
  end
  if ((N < 2) || (N > MAX_N) || ((N & (N - 1)) != 0)) begin : g_bad_n
    $error("mux_tree_pipe: N must be a power of 2 in 2..MAX_N");
  end
  if ((W < 1) || (W > 64)) begin : g_bad_w
    $error("mux_tree_pipe: W must be in 1..64");
  end

  logic             adv;
  logic             accept;
  logic [SEL_W-1:0] scan_cnt;
  logic [SEL_W-1:0] eff_sel;

  // Whole pipeline moves in lockstep; bubbles are kept, not squeezed out.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign accept   = in_valid & adv;
  assign eff_sel  = scan_mode ? scan_cnt : sel;

  // Load wins over increment; a beat accepted in the load cycle already used the old count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
    end else if (scan_load) begin
      scan_cnt <= sel;
    end else if (accept && scan_mode) begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  for (genvar k = 0; k < L; k++) begin : gen_lvl
    localparam int CI = lvl_count(N, k);
    localparam int CO = lvl_count(N, k + 1);

    logic [CI*W-1:0]       d_src;
    logic [CI-1:0]         v_src;
    logic [CI*SEL_W-1:0]   t_src;
    logic [4*CO*W-1:0]     d_in;
    logic [4*CO-1:0]       v_in;
    logic [4*CO*SEL_W-1:0] t_in;
    logic [CO*W-1:0]       d_out;
    logic [CO-1:0]         v_out;
    logic [CO*SEL_W-1:0]   t_out;

    if (k == 0) begin : g_src
      assign d_src = in_data;
      assign v_src = {CI{accept}};
      assign t_src = {CI{eff_sel}};
    end else begin : g_src
      assign d_src = gen_lvl[k-1].d_out;
      assign v_src = gen_lvl[k-1].v_out;
      assign t_src = gen_lvl[k-1].t_out;
    end

    // Only a final 2:1 level has fewer than four inputs per slice; pad slots are never picked.
    if (CI == 4 * CO) begin : g_pad
      assign d_in = d_src;
      assign v_in = v_src;
      assign t_in = t_src;
    end else begin : g_pad
      assign d_in = {{((4 * CO - CI) * W){1'b0}}, d_src};
      assign v_in = {{(4 * CO - CI){1'b0}}, v_src};
      assign t_in = {{((4 * CO - CI) * SEL_W){1'b0}}, t_src};
    end

    for (genvar j = 0; j < CO; j++) begin : gen_slice
      mux4_stage #(
        .W     (W),
        .SEL_W (SEL_W),
        .LEVEL (k)
      ) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (adv),
        .d_in  (d_in[j*4*W +: 4*W]),
        .v_in  (v_in[j*4 +: 4]),
        .t_in  (t_in[j*4*SEL_W +: 4*SEL_W]),
        .d_out (d_out[j*W +: W]),
        .v_out (v_out[j]),
        .t_out (t_out[j*SEL_W +: SEL_W])
      );
    end
  end

  assign out_data  = gen_lvl[L-1].d_out;
  assign out_valid = gen_lvl[L-1].v_out;
  assign out_sel   = gen_lvl[L-1].t_out;

endmodule
